// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with per-slot blanking and tear-free loads.
// Define SEG7_SCROLL_EN to add a scrolling message window over a MSG_LEN-nibble message.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DIGIT_CYCLES  = 1024,
  parameter int unsigned BLANK_CYCLES  = 64,
  parameter int unsigned MSG_LEN       = 16,
  parameter int unsigned SCROLL_FRAMES = 32
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef SEG7_SCROLL_EN
  input  logic [4*MSG_LEN-1:0]    data_in,
`else
  input  logic [4*NUM_DIGITS-1:0] data_in,
`endif
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

`ifdef SEG7_SCROLL_EN
  localparam int unsigned DataW = 4 * MSG_LEN;
`else
  localparam int unsigned DataW = 4 * NUM_DIGITS;
`endif
  localparam int unsigned CntW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] SlotLast  = CntW'(DIGIT_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES ||
      MSG_LEN < NUM_DIGITS || SCROLL_FRAMES < 1) begin : g_bad_params
    $error("seg7_scan_driver: invalid parameter combination");
  end

  typedef enum logic [0:0] {StBlank, StDrive} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]       digit_idx_q, digit_idx_d;
  logic [DataW-1:0]      disp_q, disp_d, stage_q, stage_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, stage_dp_q, stage_dp_d;
  logic                  pending_q, pending_d;
  logic                  slot_wrap, boundary, applied;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] an_d;
  logic [6:0]            seg_d;
  logic                  dp_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_wrap = (slot_cnt_q == SlotLast);
  assign boundary  = (digit_idx_q == IdxLast) && (slot_cnt_q == '0);

  always_comb begin
    slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (slot_wrap) begin
      digit_idx_d = (digit_idx_q == '0) ? IdxLast : digit_idx_q - 1'b1;
    end
    state_d = state_q;
    unique case (state_q)
      StBlank: if (slot_cnt_q == BlankLast) state_d = StDrive;
      StDrive: if (slot_wrap) state_d = StBlank;
      default: state_d = StBlank;
    endcase
  end

  // A load on the boundary cycle bypasses staging so latency can be zero.
  always_comb begin
    disp_d     = disp_q;
    disp_dp_d  = disp_dp_q;
    stage_d    = stage_q;
    stage_dp_d = stage_dp_q;
    pending_d  = pending_q;
    applied    = 1'b0;
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        disp_d    = data_in;
        disp_dp_d = dp_in;
        applied   = 1'b1;
      end else if (pending_q) begin
        disp_d    = stage_q;
        disp_dp_d = stage_dp_q;
        applied   = 1'b1;
      end
    end else if (load) begin
      stage_d    = data_in;
      stage_dp_d = dp_in;
      pending_d  = 1'b1;
    end
  end

`ifdef SEG7_SCROLL_EN
  localparam int unsigned OffW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned FcW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [OffW-1:0] offset_q, offset_d;
  logic [FcW-1:0]  frame_cnt_q, frame_cnt_d;
  int unsigned     char_idx;

  always_comb begin
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    if (applied) begin
      offset_d    = '0;
      frame_cnt_d = '0;
    end else if (boundary) begin
      if (frame_cnt_q == FcW'(SCROLL_FRAMES - 1)) begin
        frame_cnt_d = '0;
        offset_d    = (offset_q == OffW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Position k (0 = leftmost) shows message char (offset + k) mod MSG_LEN.
  always_comb begin
    char_idx = 32'(offset_q) + NUM_DIGITS - 32'd1 - 32'(digit_idx_q);
    if (char_idx >= MSG_LEN) char_idx = char_idx - MSG_LEN;
    nibble = disp_q[4*(MSG_LEN-1-char_idx) +: 4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  always_comb begin
    nibble = disp_q[4*digit_idx_q +: 4];
  end
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (state_q == StDrive) begin
      an_d[digit_idx_q] = 1'b0;
      seg_d             = hex_to_seg(nibble);
      dp_d              = ~disp_dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StBlank;
      slot_cnt_q  <= '0;
      digit_idx_q <= IdxLast;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      stage_q     <= '0;
      stage_dp_q  <= '0;
      pending_q   <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      stage_q     <= stage_d;
      stage_dp_q  <= stage_dp_d;
      pending_q   <= pending_d;
      an          <= an_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= boundary;
      load_ack    <= applied;
    end
  end

endmodule
